multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle Armv4 control unit: an FSM that sequences the shared-memory datapath (one ALU,
//  one memory port) over 3-5 cycles per instruction. Decodes DP/LDR/STR/B, holds NZCV flags,
//  evaluates condition codes and gates all architectural writes. Sits beside the datapath.
// PARAMETERS
//  ALU_CTRL_W   2   width of ALU_control (00 ADD, 01 SUB, 10 AND, 11 ORR)
//  FLAG_W       4   width of ALU_flags / flag register, order {N,Z,C,V}
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high
//  instruction      in   20  IR bits [31:12]: cond[31:28] op[27:26] funct[25:20] Rd[15:12]
//  ALU_flags        in   4   {N,Z,C,V} from ALU, current cycle
//  ir_write         out  1   latch instruction register
//  pc_write         out  1   write PC
//  address_source   out  1   0 = PC, 1 = ALU result register (memory address)
//  write_memory     out  1   memory write strobe
//  write_register   out  1   register file write
//  result_source    out  2   00 ALUOut reg, 01 read-data reg, 10 ALU result (direct)
//  ALU_source_a     out  2   00 Rn, 01 PC, 10 ALUOut reg
//  ALU_source_b     out  2   00 Rm/shifted, 01 extended imm, 10 constant 4
//  immediate_source out  2   00 DP imm8, 01 mem imm12, 10 branch imm24
//  register_source  out  2   [0] Rn<-R15 (branch), [1] Rm<-Rd (store)
//  ALU_control      out  2   see ALU_CTRL_W
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH.
//  reset: state<=FETCH, flags<=0000, every output 0 while asserted; reset mid-instruction aborts it.
//  FETCH: address_source=0, ir_write=1, A=PC, B=4, ADD, result_source=10, pc_write=1 -> DECODE.
//  DECODE: A=PC, B=4, ADD (PC+8 precompute, no writes). op=01 -> MEMADR; op=00 & I -> EXEI;
//   op=00 & !I -> EXER; op=10 -> BRANCH; op=11 -> FETCH (undefined = NOP).
//  MEMADR: A=Rn, B=imm12, ADD if U(funct[3]) else SUB; L(funct[0]) -> MEMRD else MEMWR.
//  MEMRD: address_source=1 -> MEMWB. MEMWB: result_source=01, write_register=cond_ok -> FETCH.
//  MEMWR: address_source=1, write_memory=cond_ok -> FETCH.
//  EXER/EXEI: A=Rn, B=Rm / imm8, ALU_control from cmd=funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND,
//   1100 ORR, others ADD -> ALUWB.
//  ALUWB: result_source=00, write_register=cond_ok & (Rd!=15 handled as PC: pc_write=cond_ok,
//   write_register=0 when Rd==15); flags update at clock edge when S & cond_ok:
//   NZ always, CV only for ADD/SUB -> FETCH.
//  BRANCH: A=ALUOut(PC+8), B=imm24<<2, ADD, result_source=10, pc_write=cond_ok -> FETCH.
//  cond_ok uses REGISTERED flags (not ALU_flags): EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V,
//   VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
//  Latency: B 3 cycles, DP 4, STR 4, LDR 5. Failed condition still consumes full cycle count.
//  Outputs are Moore in state plus combinational IR decode; no output is registered.
//  Unused selects in a state drive 0; all outputs 0 in states where not listed.
// STRUCTURE
//  Package arm_multicycle_pkg: state_t enum, ALU_control/cond-code/op localparams, source-select enums.
//  Sub-module condition_check: cond[3:0], flags[3:0] -> cond_ok (combinational, reused later).
//  Top: state register, next-state logic, output decode, flag register.
// TESTING
//  reset asserted mid-MEMRD -> state FETCH immediately, flags 0, write_register never pulses.
//  ADDS R1,R2,#1 with ALU_flags=0110 at ALUWB -> 4 cycles, write_register=1 in ALUWB, flags=0110.
//  BEQ with Z=0 -> 3 cycles, pc_write only in FETCH; with Z=1 -> pc_write also in BRANCH.
//  LDR R3,[R4,#-8] (U=0) -> ALU_control=01 in MEMADR, address_source=1 in MEMRD, write in MEMWB.
//  STRNE after CMP-equal (Z=1) -> 4 cycles, write_memory never asserted.
//  ANDS then ADDS: AND updates NZ only (C,V preserved); cond=1111 instr -> no writes, no flags.

Source files
------------

// File: rtl/arm_multicycle_pkg.sv
// arm_multicycle_pkg: shared types, encodings and ALU decode for the multicycle controller
package arm_multicycle_pkg;

    localparam int ALU_CTRL_W = 2;
    localparam int FLAG_W     = 4;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH
    } state_t;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_CTRL_W-1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic [1:0] {RES_ALUOUT, RES_RDATA, RES_ALU} result_src_t;
    typedef enum logic [1:0] {SRCA_RN, SRCA_PC, SRCA_ALUOUT} src_a_t;
    typedef enum logic [1:0] {SRCB_RM, SRCB_IMM, SRCB_FOUR} src_b_t;
    typedef enum logic [1:0] {IMM_DP, IMM_MEM, IMM_BR} imm_src_t;

    // Data-processing cmd field to ALU operation; unsupported commands fall back to ADD
    function automatic logic [ALU_CTRL_W-1:0] alu_decode(input logic [3:0] cmd);
        return cmd == 4'b0100 ? ALU_ADD :
               cmd == 4'b0010 ? ALU_SUB :
               cmd == 4'b0000 ? ALU_AND :
               cmd == 4'b1100 ? ALU_ORR : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_controller_condition_check.sv
// condition_check: evaluates an Arm condition field against {N,Z,C,V}
module condition_check
    import arm_multicycle_pkg::*;
(
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_ok
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Condition table; 1111 never executes
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = !z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = !c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = !n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = !v;
            COND_HI: cond_ok = c && !z;
            COND_LS: cond_ok = !c || z;
            COND_GE: cond_ok = n == v;
            COND_LT: cond_ok = n != v;
            COND_GT: cond_ok = !z && (n == v);
            COND_LE: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a shared-memory Armv4 datapath, with NZCV flag register
module multicycle_controller
    import arm_multicycle_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [19:0]           instruction,
    input  logic [FLAG_W-1:0]     ALU_flags,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  address_source,
    output logic                  write_memory,
    output logic                  write_register,
    output logic [1:0]            result_source,
    output logic [1:0]            ALU_source_a,
    output logic [1:0]            ALU_source_b,
    output logic [1:0]            immediate_source,
    output logic [1:0]            register_source,
    output logic [ALU_CTRL_W-1:0] ALU_control
);

    logic [3:0] cond, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ok;
    logic       unused_rn;
    logic [ALU_CTRL_W-1:0] alu_op;
    state_t      state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    assign cond      = instruction[19:16];
    assign op        = instruction[15:14];
    assign funct     = instruction[13:8];
    assign rd        = instruction[3:0];
    assign unused_rn = ^instruction[7:4];
    assign alu_op    = alu_decode(funct[4:1]);

    condition_check u_cond (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ok (cond_ok)
    );

    // Next state and flag update; flags only move in ALUWB for S-suffixed instructions that execute
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = op == OP_MEM ? MEMADR :
                               op == OP_DP  ? (funct[5] ? EXEI : EXER) :
                               op == OP_BR  ? BRANCH : FETCH;
            MEMADR:  state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXER:    state_d = ALUWB;
            EXEI:    state_d = ALUWB;
            default: state_d = FETCH;
        endcase
        flags_d = flags_q;
        if (state_q == ALUWB && funct[0] && cond_ok) begin
            flags_d[3:2] = ALU_flags[3:2];
            if (alu_op == ALU_ADD || alu_op == ALU_SUB) flags_d[1:0] = ALU_flags[1:0];
        end
    end

    // State and flag registers; reset aborts any instruction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Moore outputs per state plus IR decode; everything held low during reset
    always_comb begin
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        address_source   = 1'b0;
        write_memory     = 1'b0;
        write_register   = 1'b0;
        result_source    = RES_ALUOUT;
        ALU_source_a     = SRCA_RN;
        ALU_source_b     = SRCB_RM;
        immediate_source = IMM_DP;
        register_source  = 2'b00;
        ALU_control      = ALU_ADD;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    ir_write      = 1'b1;
                    pc_write      = 1'b1;
                    ALU_source_a  = SRCA_PC;
                    ALU_source_b  = SRCB_FOUR;
                    result_source = RES_ALU;
                end
                DECODE: begin
                    ALU_source_a    = SRCA_PC;
                    ALU_source_b    = SRCB_FOUR;
                    register_source = {op == OP_MEM && !funct[0], op == OP_BR};
                end
                MEMADR: begin
                    ALU_source_b     = SRCB_IMM;
                    immediate_source = IMM_MEM;
                    ALU_control      = funct[3] ? ALU_ADD : ALU_SUB;
                end
                MEMRD: address_source = 1'b1;
                MEMWB: begin
                    result_source  = RES_RDATA;
                    write_register = cond_ok;
                end
                MEMWR: begin
                    address_source = 1'b1;
                    write_memory   = cond_ok;
                end
                EXER: ALU_control = alu_op;
                EXEI: begin
                    ALU_source_b     = SRCB_IMM;
                    immediate_source = IMM_DP;
                    ALU_control      = alu_op;
                end
                ALUWB: begin
                    write_register = cond_ok && rd != 4'd15;
                    pc_write       = cond_ok && rd == 4'd15;
                end
                BRANCH: begin
                    ALU_source_a     = SRCA_ALUOUT;
                    ALU_source_b     = SRCB_IMM;
                    immediate_source = IMM_BR;
                    result_source    = RES_ALU;
                    pc_write         = cond_ok;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of sequencing, gating, flags and reset
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] instruction;
    logic [3:0]  ALU_flags;
    logic        ir_write, pc_write, address_source, write_memory, write_register;
    logic [1:0]  result_source, ALU_source_a, ALU_source_b, immediate_source, register_source, ALU_control;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [7:0] pcw_v, wr_v, wm_v, as_v;
    logic [1:0] alu_a [8];
    logic [1:0] rs_a  [8];

    multicycle_controller dut (
        .clock            (clock),
        .reset            (reset),
        .instruction      (instruction),
        .ALU_flags        (ALU_flags),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .address_source   (address_source),
        .write_memory     (write_memory),
        .write_register   (write_register),
        .result_source    (result_source),
        .ALU_source_a     (ALU_source_a),
        .ALU_source_b     (ALU_source_b),
        .immediate_source (immediate_source),
        .register_source  (register_source),
        .ALU_control      (ALU_control)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] enc(input logic [3:0] c, input logic [1:0] o,
                                        input logic [5:0] f, input logic [3:0] rn, input logic [3:0] rd);
        return {c, o, f, rn, rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH, recording per-cycle outputs
    task automatic run(input logic [19:0] ins, input logic [3:0] fl);
        int k;
        instruction = ins;
        ALU_flags   = fl;
        pcw_v = '0; wr_v = '0; wm_v = '0; as_v = '0;
        for (int i = 0; i < 8; i++) begin alu_a[i] = '0; rs_a[i] = '0; end
        k = 0;
        while (k < 8) begin
            pcw_v[k] = pc_write;
            wr_v[k]  = write_register;
            wm_v[k]  = write_memory;
            as_v[k]  = address_source;
            alu_a[k] = ALU_control;
            rs_a[k]  = result_source;
            @(negedge clock);
            k++;
            if (ir_write) break;
        end
        cyc = k;
    endtask

    initial begin
        reset = 1'b1;
        instruction = '0;
        ALU_flags = '0;
        repeat (2) @(negedge clock);
        chk("rst_ir_write", ir_write, 1'b0);
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_srcb", ALU_source_b, 2'b00);
        chk("rst_flags", dut.flags_q, 4'b0000);
        reset = 1'b0;
        #1;
        chk("fetch_ir_write", ir_write, 1'b1);
        chk("fetch_srcb", ALU_source_b, 2'b10);
        chk("fetch_ressrc", result_source, 2'b10);

        run(enc(4'b0000, 2'b10, 6'b100000, 4'd0, 4'd0), 4'b0000);
        chk("beq_z0_cyc", cyc, 3);
        chk("beq_z0_pcw", pcw_v, 8'b0000_0001);

        run(enc(4'b1110, 2'b00, 6'b101001, 4'd2, 4'd1), 4'b0110);
        chk("adds_cyc", cyc, 4);
        chk("adds_wr", wr_v, 8'b0000_1000);
        chk("adds_pcw", pcw_v, 8'b0000_0001);
        chk("adds_alu", alu_a[2], 2'b00);
        chk("adds_flags", dut.flags_q, 4'b0110);

        run(enc(4'b0000, 2'b10, 6'b100000, 4'd0, 4'd0), 4'b0000);
        chk("beq_z1_cyc", cyc, 3);
        chk("beq_z1_pcw", pcw_v, 8'b0000_0101);

        run(enc(4'b1110, 2'b01, 6'b010001, 4'd4, 4'd3), 4'b0000);
        chk("ldr_cyc", cyc, 5);
        chk("ldr_alu_memadr", alu_a[2], 2'b01);
        chk("ldr_as", as_v, 8'b0000_1000);
        chk("ldr_wr", wr_v, 8'b0001_0000);
        chk("ldr_ressrc", rs_a[4], 2'b01);
        chk("ldr_flags", dut.flags_q, 4'b0110);

        run(enc(4'b0001, 2'b01, 6'b011000, 4'd4, 4'd3), 4'b0000);
        chk("strne_cyc", cyc, 4);
        chk("strne_wm", wm_v, 8'b0000_0000);
        chk("strne_alu", alu_a[2], 2'b00);

        run(enc(4'b1110, 2'b01, 6'b011000, 4'd4, 4'd3), 4'b0000);
        chk("str_cyc", cyc, 4);
        chk("str_wm", wm_v, 8'b0000_1000);
        chk("str_as", as_v, 8'b0000_1000);

        run(enc(4'b1110, 2'b00, 6'b101001, 4'd2, 4'd1), 4'b0011);
        chk("adds2_flags", dut.flags_q, 4'b0011);

        run(enc(4'b1110, 2'b00, 6'b000001, 4'd0, 4'd0), 4'b1100);
        chk("ands_alu", alu_a[2], 2'b10);
        chk("ands_flags", dut.flags_q, 4'b1111);

        run(enc(4'b1110, 2'b00, 6'b011000, 4'd0, 4'd0), 4'b0000);
        chk("orr_alu", alu_a[2], 2'b11);
        chk("orr_noS_flags", dut.flags_q, 4'b1111);

        run(enc(4'b1110, 2'b00, 6'b000101, 4'd0, 4'd0), 4'b0100);
        chk("subs_alu", alu_a[2], 2'b01);
        chk("subs_flags", dut.flags_q, 4'b0100);

        run(enc(4'b1111, 2'b00, 6'b101001, 4'd2, 4'd1), 4'b1111);
        chk("nv_cyc", cyc, 4);
        chk("nv_wr", wr_v, 8'b0000_0000);
        chk("nv_pcw", pcw_v, 8'b0000_0001);
        chk("nv_flags", dut.flags_q, 4'b0100);

        run(enc(4'b1110, 2'b00, 6'b101000, 4'd2, 4'd15), 4'b0000);
        chk("pcdst_wr", wr_v, 8'b0000_0000);
        chk("pcdst_pcw", pcw_v, 8'b0000_1001);

        run(enc(4'b1110, 2'b11, 6'b000000, 4'd0, 4'd0), 4'b0000);
        chk("undef_cyc", cyc, 2);

        run(enc(4'b1110, 2'b00, 6'b101001, 4'd2, 4'd1), 4'b1010);
        chk("pre_rst_flags", dut.flags_q, 4'b1010);

        instruction = enc(4'b1110, 2'b01, 6'b010001, 4'd4, 4'd3);
        repeat (3) @(negedge clock);
        chk("memrd_as", address_source, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_as", address_source, 1'b0);
        chk("midrst_flags", dut.flags_q, 4'b0000);
        @(negedge clock);
        chk("midrst_wr", write_register, 1'b0);
        reset = 1'b0;
        #1;
        chk("postrst_fetch", ir_write, 1'b1);
        @(negedge clock);
        chk("postrst_decode_wr", write_register, 1'b0);
        chk("postrst_decode_ir", ir_write, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
